// File: rtl/cv32e40p_tmr_fault_monitor_if.sv
// Bundle of the replica inputs and the voted/fault-report outputs of the TMR fault monitor.
interface cv32e40p_tmr_fault_monitor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [WIDTH-1:0] rep0_i;
    logic [WIDTH-1:0] rep1_i;
    logic [WIDTH-1:0] rep2_i;
    logic             clear_i;
    logic [WIDTH-1:0] out_o;
    logic             valid_o;
    logic             err_detected_o;
    logic [2:0]       err_replica_o;
    logic             uncorrectable_o;
    logic [2:0]       replica_failed_o;
    logic [15:0]      err_cnt_o;

    modport master (
        output valid_i, rep0_i, rep1_i, rep2_i, clear_i,
        input  out_o, valid_o, err_detected_o, err_replica_o, uncorrectable_o,
               replica_failed_o, err_cnt_o
    );

    modport slave (
        input  valid_i, rep0_i, rep1_i, rep2_i, clear_i,
        output out_o, valid_o, err_detected_o, err_replica_o, uncorrectable_o,
               replica_failed_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR voter with per-replica health tracking and degraded duplex/simplex fallback.
// Define CV32E40P_TMR_ERR_CNT_EN to build the saturating 16-bit error counter.
module cv32e40p_tmr_fault_monitor #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned PERM_THRESHOLD = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    cv32e40p_tmr_fault_monitor_if.slave bus
);
    typedef enum logic [1:0] {StHealthy, StSuspect, StFailed} rep_state_e;

    rep_state_e       state_q [3];
    logic [3:0]       cnt_q   [3];
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             det_q;
    logic [2:0]       rep_q;
    logic             unc_q;

    logic [2:0]       failed;
    logic [1:0]       nfail;
    logic [WIDTH-1:0] voted;
    logic [WIDTH-1:0] first_active;
    logic             duplex_diff;
    logic [2:0]       mism;
    logic [WIDTH-1:0] sel_out;
    logic             unc_c;
    logic             advance;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            failed[k] = (state_q[k] == StFailed);
        end
        nfail = {1'b0, failed[0]} + {1'b0, failed[1]} + {1'b0, failed[2]};
        voted = (bus.rep0_i & bus.rep1_i) | (bus.rep0_i & bus.rep2_i) |
                (bus.rep1_i & bus.rep2_i);

        if (!failed[0])      first_active = bus.rep0_i;
        else if (!failed[1]) first_active = bus.rep1_i;
        else if (!failed[2]) first_active = bus.rep2_i;
        else                 first_active = bus.rep0_i;

        // Only meaningful in duplex mode: compare the two surviving replicas.
        if (failed[0])      duplex_diff = (bus.rep1_i != bus.rep2_i);
        else if (failed[1]) duplex_diff = (bus.rep0_i != bus.rep2_i);
        else                duplex_diff = (bus.rep0_i != bus.rep1_i);

        mism    = 3'b000;
        sel_out = first_active;
        unc_c   = 1'b1;
        unique case (nfail)
            2'd0: begin
                mism    = {bus.rep2_i != voted, bus.rep1_i != voted, bus.rep0_i != voted};
                sel_out = voted;
                unc_c   = (mism[0] & mism[1]) | (mism[0] & mism[2]) | (mism[1] & mism[2]);
            end
            2'd1: begin
                mism  = duplex_diff ? ~failed : 3'b000;
                unc_c = duplex_diff;
            end
            default: ;
        endcase
        advance = bus.valid_i && (nfail < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            det_q   <= 1'b0;
            rep_q   <= 3'b000;
            unc_q   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= StHealthy;
                cnt_q[k]   <= 4'd0;
            end
        end else begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                out_q <= sel_out;
                det_q <= |mism;
                rep_q <= mism;
                unc_q <= unc_c;
            end else begin
                det_q <= 1'b0;
                rep_q <= 3'b000;
                unc_q <= 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (bus.clear_i) begin
                    state_q[k] <= StHealthy;
                    cnt_q[k]   <= 4'd0;
                end else if (advance) begin
                    case (state_q[k])
                        StHealthy: begin
                            if (mism[k]) begin
                                state_q[k] <= StSuspect;
                                cnt_q[k]   <= 4'd1;
                            end
                        end
                        StSuspect: begin
                            if (mism[k]) begin
                                cnt_q[k] <= cnt_q[k] + 4'd1;
                                if (cnt_q[k] + 4'd1 == 4'(PERM_THRESHOLD)) begin
                                    state_q[k] <= StFailed;
                                end
                            end else begin
                                state_q[k] <= StHealthy;
                                cnt_q[k]   <= 4'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef CV32E40P_TMR_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Counts alongside err_detected_o so the value already includes the flagged sample.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear_i) begin
            err_cnt_q <= 16'd0;
        end else if (bus.valid_i && (|mism) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.err_cnt_o = 16'd0;
`endif

    assign bus.out_o            = out_q;
    assign bus.valid_o          = valid_q;
    assign bus.err_detected_o   = det_q;
    assign bus.err_replica_o    = rep_q;
    assign bus.uncorrectable_o  = unc_q;
    assign bus.replica_failed_o = {state_q[2] == StFailed, state_q[1] == StFailed,
                                   state_q[0] == StFailed};
endmodule
